// File: rtl/sobel_pkg.sv
// Shared widths, types and helpers for the Sobel edge pipeline.
// Widths are sized so no intermediate result is ever truncated.
package sobel_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int SUM_W     = PIX_W_DEF + 2;
  localparam int GRAD_W    = PIX_W_DEF + 3;

  typedef logic [SUM_W-1:0]         sum_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [GRAD_W-1:0]        mag_t;

  function automatic mag_t abs_grad(input grad_t g);
    return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
  endfunction

endpackage

// File: rtl/sobel_edge_pipe_partial_sums.sv
// Combinational Sobel partial sums: the positive and negative
// weighted row/column sums for Gx and Gy.
module sobel_partial_sums
  import sobel_pkg::*;
(
  input  logic [PIX_W_DEF-1:0] win0,
  input  logic [PIX_W_DEF-1:0] win1,
  input  logic [PIX_W_DEF-1:0] win2,
  input  logic [PIX_W_DEF-1:0] win3,
  input  logic [PIX_W_DEF-1:0] win4,
  input  logic [PIX_W_DEF-1:0] win5,
  input  logic [PIX_W_DEF-1:0] win6,
  input  logic [PIX_W_DEF-1:0] win7,
  input  logic [PIX_W_DEF-1:0] win8,
  output sum_t                 gx_pos,
  output sum_t                 gx_neg,
  output sum_t                 gy_pos,
  output sum_t                 gy_neg
);

  // The centre tap has zero weight in both kernels.
  logic win4_unused;
  assign win4_unused = ^win4;

  assign gx_pos = sum_t'(win6) + sum_t'({win3, 1'b0}) + sum_t'(win0);
  assign gx_neg = sum_t'(win8) + sum_t'({win5, 1'b0}) + sum_t'(win2);
  assign gy_pos = sum_t'(win2) + sum_t'({win1, 1'b0}) + sum_t'(win0);
  assign gy_neg = sum_t'(win8) + sum_t'({win7, 1'b0}) + sum_t'(win6);

endmodule

// File: rtl/sobel_edge_pipe.sv
// 3-stage stallable Sobel |Gx|+|Gy| pipeline with emitted-pixel counter.
// Define SOBEL_BINARY_EN for thresholded (binary) edge output.
module sobel_edge_pipe
  import sobel_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
`ifdef SOBEL_BINARY_EN
  parameter int THRESH = 128,
`endif
  parameter int CNT_W  = 20
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic [PIX_W-1:0] win0,
  input  logic [PIX_W-1:0] win1,
  input  logic [PIX_W-1:0] win2,
  input  logic [PIX_W-1:0] win3,
  input  logic [PIX_W-1:0] win4,
  input  logic [PIX_W-1:0] win5,
  input  logic [PIX_W-1:0] win6,
  input  logic [PIX_W-1:0] win7,
  input  logic [PIX_W-1:0] win8,
  input  logic             win_valid,
  output logic             win_ready,
  output logic [PIX_W-1:0] edge_pix,
  output logic             edge_valid,
  input  logic             edge_ready,
  output logic [CNT_W-1:0] edge_count
);

  localparam mag_t PIX_MAX = mag_t'((1 << PIX_W) - 1);

  sum_t gxp_c, gxn_c, gyp_c, gyn_c;
  sum_t gxp_q, gxn_q, gyp_q, gyn_q;
  sum_t gxp_d, gxn_d, gyp_d, gyn_d;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  mag_t mag_q, mag_d;
  logic [PIX_W-1:0] pix_q, pix_d, pix_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  grad_t gx, gy;
  logic advance;

  sobel_partial_sums u_sums (
    .win0   (win0),
    .win1   (win1),
    .win2   (win2),
    .win3   (win3),
    .win4   (win4),
    .win5   (win5),
    .win6   (win6),
    .win7   (win7),
    .win8   (win8),
    .gx_pos (gxp_c),
    .gx_neg (gxn_c),
    .gy_pos (gyp_c),
    .gy_neg (gyn_c)
  );

  assign advance    = !v3_q || edge_ready;
  assign win_ready  = advance && !clear;
  assign edge_valid = v3_q;
  assign edge_pix   = pix_q;
  assign edge_count = cnt_q;

  assign gx = grad_t'({1'b0, gxp_q}) - grad_t'({1'b0, gxn_q});
  assign gy = grad_t'({1'b0, gyp_q}) - grad_t'({1'b0, gyn_q});

  always_comb begin
`ifdef SOBEL_BINARY_EN
    pix_c = (mag_q >= mag_t'(THRESH)) ? '1 : '0;
`else
    pix_c = (mag_q > PIX_MAX) ? '1 : mag_q[PIX_W-1:0];
`endif
  end

  always_comb begin
    gxp_d = gxp_q;
    gxn_d = gxn_q;
    gyp_d = gyp_q;
    gyn_d = gyn_q;
    v1_d  = v1_q;
    mag_d = mag_q;
    v2_d  = v2_q;
    pix_d = pix_q;
    v3_d  = v3_q;
    cnt_d = cnt_q;
    if (clear) begin
      gxp_d = '0;
      gxn_d = '0;
      gyp_d = '0;
      gyn_d = '0;
      v1_d  = 1'b0;
      mag_d = '0;
      v2_d  = 1'b0;
      pix_d = '0;
      v3_d  = 1'b0;
      cnt_d = '0;
    end else begin
      // All stages move in lockstep; bubbles travel with the data.
      if (advance) begin
        gxp_d = gxp_c;
        gxn_d = gxn_c;
        gyp_d = gyp_c;
        gyn_d = gyn_c;
        v1_d  = win_valid;
        mag_d = abs_grad(gx) + abs_grad(gy);
        v2_d  = v1_q;
        pix_d = pix_c;
        v3_d  = v2_q;
      end
      if (v3_q && edge_ready) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      gxp_q <= '0;
      gxn_q <= '0;
      gyp_q <= '0;
      gyn_q <= '0;
      v1_q  <= 1'b0;
      mag_q <= '0;
      v2_q  <= 1'b0;
      pix_q <= '0;
      v3_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      gxp_q <= gxp_d;
      gxn_q <= gxn_d;
      gyp_q <= gyp_d;
      gyn_q <= gyn_d;
      v1_q  <= v1_d;
      mag_q <= mag_d;
      v2_q  <= v2_d;
      pix_q <= pix_d;
      v3_q  <= v3_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sobel_edge_pipe.sv
// Self-checking bench for sobel_edge_pipe: vector table, scoreboard
// queue, and directed stall / clear / reset sequences.
module tb_sobel_edge_pipe;

  logic        clk;
  logic        n_rst;
  logic        clear;
  logic [7:0]  win0, win1, win2, win3, win4, win5, win6, win7, win8;
  logic        win_valid;
  logic        win_ready;
  logic [7:0]  edge_pix;
  logic        edge_valid;
  logic        edge_ready;
  logic [19:0] edge_count;

  sobel_edge_pipe dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (clear),
    .win0       (win0),
    .win1       (win1),
    .win2       (win2),
    .win3       (win3),
    .win4       (win4),
    .win5       (win5),
    .win6       (win6),
    .win7       (win7),
    .win8       (win8),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .edge_pix   (edge_pix),
    .edge_valid (edge_valid),
    .edge_ready (edge_ready),
    .edge_count (edge_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [7:0] win_t [9];
  typedef struct {
    win_t w;
    int   exp_lin;
    int   exp_bin;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   sb[$];
  int   exp_cnt = 0;
  bit   armed = 0;
  vec_t tbl [14];
  win_t sw  [5];
  int   sexp[5];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic int model(input win_t w);
    int gx, gy, m;
    gx = (int'(w[6]) + 2 * int'(w[3]) + int'(w[0]))
       - (int'(w[8]) + 2 * int'(w[5]) + int'(w[2]));
    gy = (int'(w[2]) + 2 * int'(w[1]) + int'(w[0]))
       - (int'(w[8]) + 2 * int'(w[7]) + int'(w[6]));
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_BINARY_EN
    return (m >= 128) ? 255 : 0;
`else
    return (m > 255) ? 255 : m;
`endif
  endfunction

  task automatic set_taps(input win_t w);
    win0 = w[0]; win1 = w[1]; win2 = w[2];
    win3 = w[3]; win4 = w[4]; win5 = w[5];
    win6 = w[6]; win7 = w[7]; win8 = w[8];
  endtask

  task automatic send(input win_t w, input int exp);
    bit done = 0;
    set_taps(w);
    win_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (win_ready && n_rst && !clear) begin
        sb.push_back(exp);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    win_valid = 1'b0;
    if (!done) fail("send_timeout");
  endtask

  task automatic drain();
    bit done = 0;
    for (int t = 0; t < 60 && !done; t++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) done = 1;
    end
    if (!done) fail("drain_timeout");
  endtask

  // Scoreboard / counter monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (armed) begin
      check("edge_count", 32'(edge_count), 32'(exp_cnt));
      if (!n_rst || clear) begin
        sb.delete();
        exp_cnt = 0;
      end else if (edge_valid && edge_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %0d expected none", edge_pix);
        end else begin
          check("edge_pix", 32'(edge_pix), 32'(sb.pop_front()));
        end
        exp_cnt = (exp_cnt + 1) % (1 << 20);
      end
    end
  end

  initial begin
    win_t w;
    int   lat;
    bit   seen;

    for (int i = 0; i < 14; i++) begin
      tbl[i].w = '{default: 8'd0};
    end
    tbl[0].w = '{default: 8'd100};
    tbl[0].exp_lin = 0;    tbl[0].exp_bin = 0;
    tbl[1].w[6] = 255; tbl[1].w[3] = 255; tbl[1].w[0] = 255;
    tbl[1].exp_lin = 255;  tbl[1].exp_bin = 255;
    tbl[2].w[0] = 10;
    tbl[2].exp_lin = 20;   tbl[2].exp_bin = 0;
    tbl[3].w[8] = 255; tbl[3].w[7] = 255; tbl[3].w[6] = 255;
    tbl[3].exp_lin = 255;  tbl[3].exp_bin = 255;
    tbl[4].w[1] = 40;
    tbl[4].exp_lin = 80;   tbl[4].exp_bin = 0;
    tbl[5].w[5] = 60; tbl[5].w[1] = 20;
    tbl[5].exp_lin = 160;  tbl[5].exp_bin = 255;
    tbl[6].w[4] = 200;
    tbl[6].exp_lin = 0;    tbl[6].exp_bin = 0;
    tbl[7].w[0] = 100;
    tbl[7].exp_lin = 200;  tbl[7].exp_bin = 255;
    tbl[8].w[2] = 50;
    tbl[8].exp_lin = 100;  tbl[8].exp_bin = 0;
    tbl[9].w[6] = 70;
    tbl[9].exp_lin = 140;  tbl[9].exp_bin = 255;
    tbl[10].w[3] = 64;
    tbl[10].exp_lin = 128; tbl[10].exp_bin = 255;
    tbl[11].w[3] = 63;
    tbl[11].exp_lin = 126; tbl[11].exp_bin = 0;
    tbl[12].w[3] = 127;
    tbl[12].exp_lin = 254; tbl[12].exp_bin = 255;
    tbl[13].w[3] = 128;
    tbl[13].exp_lin = 255; tbl[13].exp_bin = 255;

    n_rst = 1'b0;
    clear = 1'b0;
    win_valid = 1'b0;
    edge_ready = 1'b1;
    w = '{default: 8'd0};
    set_taps(w);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    check("rst_edge_valid", 32'(edge_valid), 0);
    check("rst_edge_pix", 32'(edge_pix), 0);
    check("rst_edge_count", 32'(edge_count), 0);
    check("rst_win_ready", 32'(win_ready), 1);
    armed = 1;
    @(posedge clk);
    #1;

    // Latency of a single flat window.
    send(tbl[0].w, 0);
    lat = 0;
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(negedge clk);
      if (edge_valid) lat = n;
    end
    check("latency", 32'(lat), 3);
    drain();

    for (int i = 0; i < 14; i++) begin
`ifdef SOBEL_BINARY_EN
      send(tbl[i].w, tbl[i].exp_bin);
`else
      send(tbl[i].w, tbl[i].exp_lin);
`endif
    end
    drain();

    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;

    // Back-to-back stream with a 4-cycle downstream stall.
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 9; j++) sw[k][j] = 8'($urandom_range(0, 255));
      sexp[k] = model(sw[k]);
    end
    fork
      begin
        for (int k = 0; k < 5; k++) send(sw[k], sexp[k]);
      end
      begin
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
          @(posedge clk);
          #1;
          if (edge_valid) seen = 1;
        end
        if (!seen) fail("stream_first_out");
        edge_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("stall_pix", 32'(edge_pix), 32'(sexp[0]));
          check("stall_valid", 32'(edge_valid), 1);
          check("stall_win_ready", 32'(win_ready), 0);
          @(posedge clk);
          #1;
        end
        edge_ready = 1'b1;
      end
    join
    drain();
    @(negedge clk);
    check("stream_count", 32'(edge_count), 5);
    @(posedge clk);
    #1;

    // Clear with two windows in flight.
    send(tbl[1].w, 255);
    send(tbl[3].w, 255);
    clear = 1'b1;
    set_taps(tbl[7].w);
    win_valid = 1'b1;
    @(negedge clk);
    check("clear_win_ready", 32'(win_ready), 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    win_valid = 1'b0;
    @(negedge clk);
    check("clear_edge_valid", 32'(edge_valid), 0);
    check("clear_edge_count", 32'(edge_count), 0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (edge_valid) seen = 1;
    end
    check("clear_no_output", 32'(seen), 0);
    @(posedge clk);
    #1;

    // Reset mid-stream while an output is held.
    send(tbl[2].w, model(tbl[2].w));
    send(tbl[4].w, model(tbl[4].w));
    drain();
    edge_ready = 1'b0;
    send(tbl[5].w, model(tbl[5].w));
    send(tbl[7].w, model(tbl[7].w));
    send(tbl[9].w, model(tbl[9].w));
    @(negedge clk);
    check("pre_rst_valid", 32'(edge_valid), 1);
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    edge_ready = 1'b1;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(edge_valid), 0);
    check("mid_rst_pix", 32'(edge_pix), 0);
    check("mid_rst_count", 32'(edge_count), 0);
    check("mid_rst_win_ready", 32'(win_ready), 1);
    @(posedge clk);
    #1;
    send(tbl[13].w, model(tbl[13].w));
    drain();
    @(negedge clk);
    check("post_rst_count", 32'(edge_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_edge_pipe.md
Name: sobel_edge_pipe

Overview:
- Downstream consumer of the 9-tap pixel window shift register in the image edge detection datapath.
- Takes one 3x3 window per accepted transfer and computes the Sobel gradient magnitude |Gx|+|Gy|.
- Emits one 8-bit edge pixel per window through a 3-stage stallable pipeline with valid/ready handshake.
- Counts emitted pixels for the frame controller.

Parameters:
- PIX_W, 8, pixel width in bits; output width equals PIX_W.
- THRESH, 128, magnitude threshold; used only when SOBEL_BINARY_EN is defined.
- CNT_W, 20, width of the emitted-pixel counter (covers 640x480 frames).

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset, synchronous, active-low.
- clear  in  1  synchronous flush of the pipeline and the counter.
- win0..win8  in  PIX_W each  window taps; win0 is newest, win8 oldest.
- win_valid  in  1  window taps are valid this cycle.
- win_ready  out  1  block accepts the window this cycle.
- edge_pix  out  PIX_W  edge output pixel.
- edge_valid  out  1  edge_pix is valid.
- edge_ready  in  1  downstream accepts edge_pix.
- edge_count  out  CNT_W  number of edge pixels accepted downstream since reset/clear.

Behaviour:
- Window layout:
  - Top row: win8 win7 win6.
  - Mid row: win5 win4 win3.
  - Bottom row: win2 win1 win0.
- Gradient equations:
  - Gx = (win6 + 2*win3 + win0) - (win8 + 2*win5 + win2).
  - Gy = (win2 + 2*win1 + win0) - (win8 + 2*win7 + win6).
- Arithmetic widths:
  - Partial sums are unsigned PIX_W+2 bits (max 1020).
  - Differences are signed PIX_W+3 bits.
  - Magnitude is unsigned PIX_W+3 bits (max 2040).
  - No intermediate truncation.
- Stage 1 registers the four partial sums.
- Stage 2 registers mag = |Gx| + |Gy|.
- Stage 3 registers the output pixel: saturated magnitude, min(mag, 2^PIX_W-1).
- Each stage has a valid bit; edge_valid is the stage-3 valid.
- advance = !edge_valid | edge_ready.
  - When advance is high, all three stages shift together; bubbles are carried, not collapsed.
  - When advance is low, all stage registers and valids hold.
- win_ready = advance & !clear. A transfer occurs when win_valid & win_ready.
- Latency: 3 cycles from transfer to edge_valid with no stall. Throughput is one window per cycle.
- edge_pix must not change while edge_valid is high and edge_ready is low.
- edge_count increments by 1 on each edge_valid & edge_ready. It wraps at 2^CNT_W-1 to 0 silently.
- Reset (n_rst low at posedge):
  - All stage valids = 0 and all data registers = 0.
  - edge_pix = 0, edge_valid = 0, edge_count = 0.
  - win_ready = 1 in the first cycle after reset release.
- Priority: n_rst over clear over normal operation.
- clear high at a posedge:
  - All stage valids = 0, data registers = 0, edge_count = 0.
  - In-flight windows are discarded.
  - A window presented in the same cycle is not accepted, since win_ready is low.
- Reset or clear asserted mid-stall discards the held output; no transfer is counted in that cycle.

Optional Feature:
- Macro: SOBEL_BINARY_EN.
- Defined: stage 3 outputs 2^PIX_W-1 when mag >= THRESH, else 0. THRESH is compared at full PIX_W+3 width.
- Undefined: stage 3 outputs the saturated magnitude; THRESH is unused.
- Latency, handshake and counter behaviour are identical in both builds.

Decomposition:
- Package sobel_pkg holds:
  - Constants PIX_W_DEF, SUM_W = PIX_W+2, GRAD_W = PIX_W+3.
  - Typedef sum_t for partial sums.
  - Typedef grad_t for signed differences.
  - Typedef mag_t for magnitude.
  - Function abs_grad.
- One sub-module, sobel_partial_sums: purely combinational; 9 taps in, four sum_t out.
- The pipeline registers, handshake and counter stay in the top module.

Test Plan:
- Flat window, all taps 100, edge_ready=1 -> edge_pix=0, edge_valid 3 cycles after transfer.
- Vertical edge: win8,win5,win2=0; win6,win3,win0=255; rest 0 -> Gx=1020, Gy=0, edge_pix=255 in both builds.
- win0=10, all others 0 -> mag=20. Default build: edge_pix=20. SOBEL_BINARY_EN build: edge_pix=0.
- Back-to-back stream of 5 windows:
  - Hold edge_ready=0 for 4 cycles after the first output -> edge_pix stable and win_ready=0 during the stall.
  - All 5 results emerge in order; edge_count=5.
- clear asserted with 2 windows in flight -> edge_valid=0 next cycle, edge_count=0, window presented with clear not accepted.
- n_rst low for one cycle mid-stream with edge_valid=1 -> all outputs 0 the next cycle, win_ready=1 after release, edge_count restarts at 0.
